// File: rtl/uart_rom_loader_pkg.sv
// Shared definitions for the UART program loader: FSM encodings,
// protocol constants and a small state-classification helper.
package uart_rom_loader_pkg;

  // Loader protocol FSM states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_DONE   = 3'd4,
    ST_ERR    = 3'd5
  } ld_state_t;

  // UART receiver bit-level states.
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam logic [7:0] LD_SYNC_BYTE = 8'hA5;
  localparam int         LD_CNT_W     = 16;

  // A load is in progress (timeout armed, framing errors abort).
  function automatic logic is_busy(input ld_state_t s);
    return (s == ST_CNT_LO) || (s == ST_CNT_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/uart_rom_loader_rx.sv
// 8N1 UART byte receiver: 2-FF synchronizer, falling-edge start detect,
// mid-bit sampling, one-cycle byte_vld / frm_err pulses.
module uart_rx_byte
  import uart_rom_loader_pkg::*;
#(
  parameter int BIT_CYC = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  output logic       byte_vld,
  output logic [7:0] byte_o,
  output logic       frm_err
);

  localparam int            CW      = (BIT_CYC > 2) ? $clog2(BIT_CYC) : 2;
  localparam logic [CW-1:0] FULL_M1 = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_CYC / 2 - 1);

  // [0],[1] form the synchronizer; [2] is history for edge detection.
  logic [2:0]    sync_reg;
  rx_state_t     state_reg, state_next;
  logic [CW-1:0] bit_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic [7:0]    shift_reg;
  logic          vld_reg, ferr_reg;
  logic [7:0]    byte_reg;

  logic rx_s, fall, tick_full, tick_half;

  assign rx_s      = sync_reg[1];
  assign fall      = sync_reg[2] & ~sync_reg[1];
  assign tick_full = (bit_cnt_reg == FULL_M1);
  assign tick_half = (bit_cnt_reg == HALF_M1);

  // Bring the asynchronous line into the clock domain.
  always_ff @(posedge clk) begin
    if (rst) sync_reg <= 3'b111;
    else     sync_reg <= {sync_reg[1:0], rx_line};
  end

  // Receiver state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= RX_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state: start-bit check at half period, then 8 data bits and a stop bit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RX_IDLE:  if (fall) state_next = RX_START;
      RX_START: if (tick_half) state_next = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA:  if (tick_full && bit_idx_reg == 3'd7) state_next = RX_STOP;
      RX_STOP:  if (tick_full) state_next = RX_IDLE;
      default:  state_next = RX_IDLE;
    endcase
  end

  // Bit timer, LSB-first shifter and result pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      vld_reg     <= 1'b0;
      ferr_reg    <= 1'b0;
      byte_reg    <= '0;
    end else begin
      vld_reg  <= 1'b0;
      ferr_reg <= 1'b0;
      case (state_reg)
        RX_IDLE: begin
          bit_cnt_reg <= '0;
          bit_idx_reg <= '0;
        end
        RX_START: bit_cnt_reg <= tick_half ? '0 : bit_cnt_reg + 1'b1;
        RX_DATA: begin
          if (tick_full) begin
            bit_cnt_reg <= '0;
            shift_reg   <= {rx_s, shift_reg[7:1]};
            bit_idx_reg <= bit_idx_reg + 3'd1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        RX_STOP: begin
          if (tick_full) begin
            bit_cnt_reg <= '0;
            if (rx_s) begin
              vld_reg  <= 1'b1;
              byte_reg <= shift_reg;
            end else begin
              ferr_reg <= 1'b1;
            end
          end else begin
            bit_cnt_reg <= bit_cnt_reg + 1'b1;
          end
        end
        default: bit_cnt_reg <= '0;
      endcase
    end
  end

  assign byte_vld = vld_reg;
  assign byte_o   = byte_reg;
  assign frm_err  = ferr_reg;

endmodule

// File: rtl/uart_rom_loader.sv
// Boot loader: receives A5 / N(16b LE) / 4N bytes over UART, writes
// little-endian words to the instruction ROM, holds the core in reset
// until the image is complete.
module uart_rom_loader
  import uart_rom_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int ROM_AW      = 12,
  parameter int TIMEOUT_CYC = CLK_FREQ / 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              uart_rx_i,
  output logic              rom_wr_en_o,
  output logic [ROM_AW-1:0] rom_wr_addr_o,
  output logic [31:0]       rom_wr_data_o,
  output logic              core_rst_o,
  output logic              busy_o,
  output logic              load_done_o,
  output logic              load_err_o
);

  localparam int                BIT_CYC = CLK_FREQ / BAUD;
  localparam logic [LD_CNT_W:0] DEPTH   = (LD_CNT_W + 1)'(2 ** ROM_AW);
  localparam int                TW      = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0]     TO_M1   = TW'(TIMEOUT_CYC - 1);

  logic       rx_vld, rx_frm_err;
  logic [7:0] rx_byte;

  uart_rx_byte #(.BIT_CYC(BIT_CYC)) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rx_line  (uart_rx_i),
    .byte_vld (rx_vld),
    .byte_o   (rx_byte),
    .frm_err  (rx_frm_err)
  );

  ld_state_t           state_reg, state_next;
  logic [LD_CNT_W-1:0] cnt_reg;
  logic [LD_CNT_W-1:0] word_idx_reg;
  logic [1:0]          byte_idx_reg;
  logic [23:0]         asm_reg;
  logic [TW-1:0]       to_cnt_reg;
  logic                wr_en_reg;
  logic [ROM_AW-1:0]   wr_addr_reg;
  logic [31:0]         wr_data_reg;

  logic [LD_CNT_W-1:0] n_full;
  logic                timeout_hit, wr_fire;

  // Protocol state register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic; framing errors and timeouts abort any busy state.
  // to_cnt_reg is 0 in the first cycle after a byte, so matching T-1
  // means T idle cycles have elapsed and ERR shows in the one after.
  always_comb begin
    state_next  = state_reg;
    n_full      = {rx_byte, cnt_reg[7:0]};
    timeout_hit = (to_cnt_reg == TO_M1) && !rx_vld;
    wr_fire     = (state_reg == ST_DATA) && rx_vld && (byte_idx_reg == 2'd3);
    case (state_reg)
      ST_IDLE:   if (rx_vld && rx_byte == LD_SYNC_BYTE) state_next = ST_CNT_LO;
      ST_CNT_LO: if (rx_vld) state_next = ST_CNT_HI;
      ST_CNT_HI: begin
        if (rx_vld) begin
          if (n_full == '0)                  state_next = ST_DONE;
          else if ({1'b0, n_full} > DEPTH)   state_next = ST_ERR;
          else                               state_next = ST_DATA;
        end
      end
      // The last word's strobe is out this cycle; DONE follows next cycle.
      ST_DATA:   if (word_idx_reg == cnt_reg) state_next = ST_DONE;
      ST_DONE:   state_next = ST_DONE;
      ST_ERR:    if (rx_vld && rx_byte == LD_SYNC_BYTE) state_next = ST_CNT_LO;
      default:   state_next = ST_IDLE;
    endcase
    if (is_busy(state_reg) && (rx_frm_err || timeout_hit)) state_next = ST_ERR;
  end

  // Count latch, word assembly, address counter, write port, timeout counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg      <= '0;
      word_idx_reg <= '0;
      byte_idx_reg <= '0;
      asm_reg      <= '0;
      to_cnt_reg   <= '0;
      wr_en_reg    <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
    end else begin
      wr_en_reg <= wr_fire;
      if (state_reg == ST_CNT_LO && rx_vld) cnt_reg[7:0] <= rx_byte;
      if (state_reg == ST_CNT_HI && rx_vld) begin
        cnt_reg[15:8] <= rx_byte;
        word_idx_reg  <= '0;
        byte_idx_reg  <= '0;
      end
      if (state_reg == ST_DATA && rx_vld) begin
        byte_idx_reg <= byte_idx_reg + 2'd1;
        case (byte_idx_reg)
          2'd0:    asm_reg[7:0]   <= rx_byte;
          2'd1:    asm_reg[15:8]  <= rx_byte;
          2'd2:    asm_reg[23:16] <= rx_byte;
          default: begin
            wr_addr_reg  <= word_idx_reg[ROM_AW-1:0];
            wr_data_reg  <= {rx_byte, asm_reg};
            word_idx_reg <= word_idx_reg + 1'b1;
          end
        endcase
      end
      if (!is_busy(state_reg) || rx_vld) to_cnt_reg <= '0;
      else                               to_cnt_reg <= to_cnt_reg + 1'b1;
    end
  end

  assign rom_wr_en_o   = wr_en_reg;
  assign rom_wr_addr_o = wr_addr_reg;
  assign rom_wr_data_o = wr_data_reg;
  assign core_rst_o    = (state_reg != ST_DONE);
  assign load_done_o   = (state_reg == ST_DONE);
  assign load_err_o    = (state_reg == ST_ERR);
  assign busy_o        = is_busy(state_reg);

endmodule
